// File: rtl/alu_rs_param_pkg.sv
// ============================================================================
//  Module   : alu_rs_param_pkg
//  Purpose  : Shared ALU op encodings and tag constants for the ALU station
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_rs_param_pkg;

    localparam int OP_W     = 4;
    localparam int TAG_FREE = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_SLL  = 4'd3,
        OP_SLT  = 4'd4,
        OP_SLTU = 4'd5,
        OP_XOR  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_OR   = 4'd9,
        OP_AND  = 4'd10,
        OP_LUI  = 4'd11,
        OP_JAL  = 4'd12,
        OP_JALR = 4'd13
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/alu_rs_age_matrix.sv
// ============================================================================
//  Module   : alu_rs_age_matrix
//  Purpose  : Age matrix selecting the oldest ready reservation-station entry
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rs_age_matrix #(
    parameter int RS_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [RS_DEPTH-1:0] alloc,
    input  logic [RS_DEPTH-1:0] free,
    input  logic [RS_DEPTH-1:0] ready,
    output logic [RS_DEPTH-1:0] oldest
);

    // r_age[i][j] set means entry i is older than entry j; diagonal stays zero
    logic [RS_DEPTH-1:0] r_age [RS_DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < RS_DEPTH; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (i == j)
                        r_age[i][j] <= 1'b0;
                    else if (alloc[j])
                        r_age[i][j] <= 1'b1;
                    else if (alloc[i] || free[i] || free[j])
                        r_age[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        oldest = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            oldest[i] = ready[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (ready[j] && r_age[j][i]) oldest[i] = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rs_param.sv
// ============================================================================
//  Module   : alu_rs_param
//  Purpose  : Parametrised ALU reservation station with oldest-first issue,
//             N-port CDB snoop and a held result stage
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rs_param
    import alu_rs_param_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int TAG_W    = 4,
    parameter int N_CDB    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [OP_W-1:0]         disp_op,
    input  logic [TAG_W-1:0]        disp_dest,
    input  logic [TAG_W-1:0]        disp_tag1,
    input  logic [TAG_W-1:0]        disp_tag2,
    input  logic [DATA_W-1:0]       disp_data1,
    input  logic [DATA_W-1:0]       disp_data2,
    input  logic [ADDR_W-1:0]       disp_pc,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_W-1:0] cdb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TAG_W-1:0]        out_tag,
    output logic [DATA_W-1:0]       out_data,
    output logic [ADDR_W-1:0]       out_target,
    output logic                    out_pc_valid
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int SH_W  = $clog2(DATA_W);
    localparam logic [TAG_W-1:0] C_TAG_FREE = TAG_W'(TAG_FREE);

    typedef struct packed {
        logic              valid;
        alu_op_e           op;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  tag1;
        logic [DATA_W-1:0] data1;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] data2;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } snoop_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] target;
        logic              pc_valid;
    } result_t;

    // Lowest CDB port wins when several carry the same tag
    function automatic snoop_t cdb_lookup(input logic [TAG_W-1:0] tag);
        snoop_t s;
        s = '0;
        for (int p = N_CDB - 1; p >= 0; p--) begin
            if (cdb_valid[p] && tag != C_TAG_FREE && cdb_tag[p*TAG_W +: TAG_W] == tag) begin
                s.hit  = 1'b1;
                s.data = cdb_data[p*DATA_W +: DATA_W];
            end
        end
        return s;
    endfunction

    function automatic result_t execute(input entry_t e);
        result_t          r;
        logic [SH_W-1:0]  sh;
        r  = '0;
        sh = e.data2[SH_W-1:0];
        case (e.op)
            OP_ADD:  r.data = e.data1 + e.data2;
            OP_SUB:  r.data = e.data1 - e.data2;
            OP_SLL:  r.data = e.data1 << sh;
            OP_SLT:  r.data = DATA_W'($signed(e.data1) < $signed(e.data2));
            OP_SLTU: r.data = DATA_W'(e.data1 < e.data2);
            OP_XOR:  r.data = e.data1 ^ e.data2;
            OP_SRL:  r.data = e.data1 >> sh;
            OP_SRA:  r.data = DATA_W'($signed(e.data1) >>> sh);
            OP_OR:   r.data = e.data1 | e.data2;
            OP_AND:  r.data = e.data1 & e.data2;
            OP_LUI:  r.data = e.data2;
            OP_JAL: begin
                r.target   = e.pc + ADDR_W'(e.data2);
                r.data     = DATA_W'(e.pc + ADDR_W'(4));
                r.pc_valid = 1'b1;
            end
            OP_JALR: begin
                r.target   = ADDR_W'(e.data1 + e.data2) & ~ADDR_W'(1);
                r.data     = DATA_W'(e.pc + ADDR_W'(4));
                r.pc_valid = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    entry_t              r_ent [RS_DEPTH];
    logic                r_out_valid;
    logic [TAG_W-1:0]    r_out_tag;
    logic [DATA_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_target;
    logic                r_out_pc_valid;

    logic [RS_DEPTH-1:0] w_ready;
    logic [RS_DEPTH-1:0] w_oldest;
    logic [RS_DEPTH-1:0] w_issue_oh;
    logic [RS_DEPTH-1:0] w_alloc_oh;
    logic [IDX_W-1:0]    w_alloc_idx;
    logic                w_accept;
    logic                w_can_issue;
    entry_t              w_issue_ent;
    entry_t              w_new;
    result_t             w_result;
    snoop_t              w_s1 [RS_DEPTH];
    snoop_t              w_s2 [RS_DEPTH];
    snoop_t              w_b1;
    snoop_t              w_b2;

    always_comb begin
        disp_ready  = 1'b0;
        w_alloc_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_ent[i].valid) begin
                disp_ready  = 1'b1;
                w_alloc_idx = IDX_W'(i);
            end
        end
        w_accept   = disp_valid && disp_ready && (disp_op != OP_NOP);
        w_alloc_oh = '0;
        if (w_accept) w_alloc_oh[w_alloc_idx] = 1'b1;
    end

    always_comb begin
        w_issue_ent = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_ready[i] = r_ent[i].valid && r_ent[i].tag1 == C_TAG_FREE
                                        && r_ent[i].tag2 == C_TAG_FREE;
            w_s1[i]    = cdb_lookup(r_ent[i].tag1);
            w_s2[i]    = cdb_lookup(r_ent[i].tag2);
            if (w_oldest[i]) w_issue_ent = r_ent[i];
        end
        w_can_issue = (|w_ready) && (!r_out_valid || out_ready);
        w_issue_oh  = w_can_issue ? w_oldest : '0;
        w_result    = execute(w_issue_ent);
    end

    // Operands broadcast in the dispatch cycle are captured directly
    always_comb begin
        w_b1        = cdb_lookup(disp_tag1);
        w_b2        = cdb_lookup(disp_tag2);
        w_new.valid = 1'b1;
        w_new.op    = alu_op_e'(disp_op);
        w_new.dest  = disp_dest;
        w_new.tag1  = w_b1.hit ? C_TAG_FREE : disp_tag1;
        w_new.data1 = w_b1.hit ? w_b1.data  : disp_data1;
        w_new.tag2  = w_b2.hit ? C_TAG_FREE : disp_tag2;
        w_new.data2 = w_b2.hit ? w_b2.data  : disp_data2;
        w_new.pc    = disp_pc;
    end

    alu_rs_age_matrix #(
        .RS_DEPTH (RS_DEPTH)
    ) u_age (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .alloc  (w_alloc_oh),
        .free   (w_issue_oh),
        .ready  (w_ready),
        .oldest (w_oldest)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < RS_DEPTH; i++) r_ent[i] <= '0;
            r_out_valid    <= 1'b0;
            r_out_tag      <= C_TAG_FREE;
            r_out_data     <= '0;
            r_out_target   <= '0;
            r_out_pc_valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (w_issue_oh[i]) begin
                    r_ent[i].valid <= 1'b0;
                end else if (w_alloc_oh[i]) begin
                    r_ent[i] <= w_new;
                end else if (r_ent[i].valid) begin
                    if (w_s1[i].hit) begin
                        r_ent[i].tag1  <= C_TAG_FREE;
                        r_ent[i].data1 <= w_s1[i].data;
                    end
                    if (w_s2[i].hit) begin
                        r_ent[i].tag2  <= C_TAG_FREE;
                        r_ent[i].data2 <= w_s2[i].data;
                    end
                end
            end
            if (w_can_issue) begin
                r_out_valid    <= 1'b1;
                r_out_tag      <= w_issue_ent.dest;
                r_out_data     <= w_result.data;
                r_out_target   <= w_result.target;
                r_out_pc_valid <= w_result.pc_valid;
            end else if (out_ready) begin
                r_out_valid    <= 1'b0;
                r_out_tag      <= C_TAG_FREE;
                r_out_data     <= '0;
                r_out_target   <= '0;
                r_out_pc_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_tag      = r_out_tag;
    assign out_data     = r_out_data;
    assign out_target   = r_out_target;
    assign out_pc_valid = r_out_pc_valid;

endmodule

`default_nettype wire
